// File: rtl/display_scan_ctrl_if.sv
// display_scan_ctrl_if: value handshake plus committed-result and scan outputs of the display controller
interface display_scan_ctrl_if #(
  parameter int NB_DATA = 8,
  parameter int NB_BCD  = 12
);
  logic               i_valid;
  logic [NB_DATA-1:0] i_data;
  logic               i_sign;
  logic               o_ready;
  logic               o_done;
  logic [NB_BCD-1:0]  o_bcd;
  logic               o_negative;
  logic [3:0]         o_an;
  logic [6:0]         o_seg;
  modport master (
    output i_valid, i_data, i_sign,
    input  o_ready, o_done, o_bcd, o_negative, o_an, o_seg
  );
  modport slave (
    input  i_valid, i_data, i_sign,
    output o_ready, o_done, o_bcd, o_negative, o_an, o_seg
  );
endinterface

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: serial double-dabble converter feeding a 4-digit multiplexed 7-segment scanner
module display_scan_ctrl #(
  parameter int NB_DATA     = 8,
  parameter int NB_BCD      = 12,
  parameter int REFRESH_DIV = 50000
) (
  input logic i_clk,
  input logic i_rst,
  display_scan_ctrl_if.slave bus
);
  localparam int NB_SH  = NB_BCD + NB_DATA;
  localparam int NB_IT  = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;
  localparam int NB_REF = $clog2(REFRESH_DIV);
  localparam logic [6:0] BLANK = 7'b1111111;
  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;
  state_t             state_q, state_d;
  logic [NB_SH-1:0]   sh_q, sh_d, adj;
  logic [NB_IT-1:0]   it_q, it_d;
  logic               sgn_q, sgn_d, neg_q, neg_d, done_q, done_d, neg_in;
  logic [NB_BCD-1:0]  bcd_q, bcd_d;
  logic [NB_DATA-1:0] mag;
  logic [NB_REF-1:0]  ref_q, ref_d;
  logic [1:0]         dig_q, dig_d;
  logic [3:0]         an_q, an_d;
  logic [6:0]         seg_q, seg_d;
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: seg7 = 7'b1000000;
      4'd1: seg7 = 7'b1111001;
      4'd2: seg7 = 7'b0100100;
      4'd3: seg7 = 7'b0110000;
      4'd4: seg7 = 7'b0011001;
      4'd5: seg7 = 7'b0010010;
      4'd6: seg7 = 7'b0000010;
      4'd7: seg7 = 7'b1111000;
      4'd8: seg7 = 7'b0000000;
      4'd9: seg7 = 7'b0010000;
      default: seg7 = BLANK;
    endcase
  endfunction
  assign neg_in = bus.i_sign & bus.i_data[NB_DATA-1];
  assign mag    = neg_in ? -bus.i_data : bus.i_data;
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    it_d    = it_q;
    sgn_d   = sgn_q;
    bcd_d   = bcd_q;
    neg_d   = neg_q;
    done_d  = 1'b0;
    adj     = sh_q;
    for (int n = 0; n < NB_BCD / 4; n++)
      adj[NB_DATA+4*n +: 4] = (adj[NB_DATA+4*n +: 4] >= 4'd5) ? adj[NB_DATA+4*n +: 4] + 4'd3 : adj[NB_DATA+4*n +: 4];
    if (state_q == IDLE && bus.i_valid) begin
      sh_d    = {{NB_BCD{1'b0}}, mag};
      sgn_d   = neg_in;
      it_d    = '0;
      state_d = CONV;
    end else if (state_q == CONV) begin
      sh_d    = {adj[NB_SH-2:0], 1'b0};
      it_d    = it_q + 1'b1;
      state_d = (it_q == NB_IT'(NB_DATA - 1)) ? COMMIT : CONV;
    end else if (state_q == COMMIT) begin
      bcd_d   = sh_q[NB_DATA +: NB_BCD];
      neg_d   = sgn_q;
      done_d  = 1'b1;
      state_d = IDLE;
    end
    ref_d = (ref_q == NB_REF'(REFRESH_DIV - 1)) ? '0 : ref_q + 1'b1;
    dig_d = (ref_q == NB_REF'(REFRESH_DIV - 1)) ? dig_q + 2'd1 : dig_q;
    an_d  = ~(4'b0001 << dig_d);
    // segments follow the value being committed so o_seg never lags o_bcd
    seg_d = (dig_d == 2'd0) ? seg7(bcd_d[3:0]) :
            (dig_d == 2'd1) ? ((bcd_d[11:4] == 8'd0) ? BLANK : seg7(bcd_d[7:4])) :
            (dig_d == 2'd2) ? ((bcd_d[11:8] == 4'd0) ? BLANK : seg7(bcd_d[11:8])) :
            (neg_d ? 7'b0111111 : BLANK);
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      it_q    <= '0;
      sgn_q   <= 1'b0;
      bcd_q   <= '0;
      neg_q   <= 1'b0;
      done_q  <= 1'b0;
      ref_q   <= '0;
      dig_q   <= 2'd0;
      an_q    <= 4'b1110;
      seg_q   <= 7'b1000000;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      it_q    <= it_d;
      sgn_q   <= sgn_d;
      bcd_q   <= bcd_d;
      neg_q   <= neg_d;
      done_q  <= done_d;
      ref_q   <= ref_d;
      dig_q   <= dig_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end
  assign bus.o_ready    = (state_q == IDLE);
  assign bus.o_done     = done_q;
  assign bus.o_bcd      = bcd_q;
  assign bus.o_negative = neg_q;
  assign bus.o_an       = an_q;
  assign bus.o_seg      = seg_q;
endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: vector table plus scoreboard on o_done, and hand sequences for scan, back-to-back and abort
module tb_display_scan_ctrl;
  localparam int NB_DATA = 8;
  localparam int NB_BCD  = 12;
  localparam int DIV     = 4;
  typedef struct {
    logic [11:0] bcd;
    logic        neg;
    int          acc;
  } exp_t;
  typedef struct {
    logic [7:0]  data;
    logic        sign;
    logic [11:0] bcd;
    logic        neg;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t got;
  vec_t vecs[10];
  logic [6:0] lut[10];
  display_scan_ctrl_if #(.NB_DATA(NB_DATA), .NB_BCD(NB_BCD)) bus ();
  display_scan_ctrl #(.NB_DATA(NB_DATA), .NB_BCD(NB_BCD), .REFRESH_DIV(DIV)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus.slave)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, a, e, cyc);
    end
  endtask
  always @(negedge clk) begin
    if (!rst && bus.o_done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got o_done=1 expected 0 (cycle %0d)", cyc);
      end else begin
        got = sb.pop_front();
        chk("done_bcd", {20'd0, bus.o_bcd}, {20'd0, got.bcd});
        chk("done_negative", {31'd0, bus.o_negative}, {31'd0, got.neg});
        chk("done_latency", cyc - got.acc, NB_DATA + 1);
      end
    end
  end
  function automatic int an_idx(input logic [3:0] an);
    case (an)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction
  function automatic logic [6:0] exp_seg(input int idx, input logic [11:0] b, input logic n);
    if (idx == 0) return lut[b[3:0]];
    if (idx == 1) return (b[11:8] == 0 && b[7:4] == 0) ? 7'b1111111 : lut[b[7:4]];
    if (idx == 2) return (b[11:8] == 0) ? 7'b1111111 : lut[b[11:8]];
    return n ? 7'b0111111 : 7'b1111111;
  endfunction
  task automatic send(input logic [7:0] d, input logic s, input logic [11:0] eb, input logic en);
    int t = 0;
    @(negedge clk);
    while (!bus.o_ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (!bus.o_ready) begin
      chk("send_ready_timeout", {31'd0, bus.o_ready}, 32'd1);
      return;
    end
    bus.i_valid = 1'b1;
    bus.i_data  = d;
    bus.i_sign  = s;
    @(posedge clk);
    #1;
    sb.push_back('{eb, en, cyc});
    bus.i_valid = 1'b0;
  endtask
  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) chk("done_timeout", sb.size(), 0);
    sb.delete();
  endtask
  task automatic check_display(input logic [11:0] eb, input logic en);
    int idx;
    for (int i = 0; i < 4 * DIV; i++) begin
      @(negedge clk);
      idx = an_idx(bus.o_an);
      if (idx < 0) chk("an_onehot", {28'd0, bus.o_an}, 32'hE);
      else chk($sformatf("seg_digit%0d", idx), {25'd0, bus.o_seg}, {25'd0, exp_seg(idx, eb, en)});
    end
  endtask
  task automatic check_reset_state(input string tag);
    chk({tag, "_ready"}, {31'd0, bus.o_ready}, 32'd1);
    chk({tag, "_done"}, {31'd0, bus.o_done}, 32'd0);
    chk({tag, "_bcd"}, {20'd0, bus.o_bcd}, 32'd0);
    chk({tag, "_negative"}, {31'd0, bus.o_negative}, 32'd0);
    chk({tag, "_an"}, {28'd0, bus.o_an}, 32'b1110);
    chk({tag, "_seg"}, {25'd0, bus.o_seg}, 32'b1000000);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n, d0;
    lut = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    vecs[0] = '{8'd123, 1'b0, 12'h123, 1'b0};
    vecs[1] = '{8'hCE,  1'b1, 12'h050, 1'b1};
    vecs[2] = '{8'h80,  1'b1, 12'h128, 1'b1};
    vecs[3] = '{8'h80,  1'b0, 12'h128, 1'b0};
    vecs[4] = '{8'hFF,  1'b0, 12'h255, 1'b0};
    vecs[5] = '{8'hFF,  1'b1, 12'h001, 1'b1};
    vecs[6] = '{8'h7F,  1'b1, 12'h127, 1'b0};
    vecs[7] = '{8'h00,  1'b1, 12'h000, 1'b0};
    vecs[8] = '{8'd10,  1'b0, 12'h010, 1'b0};
    vecs[9] = '{8'd99,  1'b1, 12'h099, 1'b0};
    bus.i_valid = 1'b0;
    bus.i_data  = '0;
    bus.i_sign  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_reset_state("reset");
    send(8'd7, 1'b0, 12'h007, 1'b0);
    drain();
    n = 0;
    @(negedge clk);
    d0 = an_idx(bus.o_an);
    while (an_idx(bus.o_an) == d0 && n < 2 * DIV) begin
      @(negedge clk);
      n++;
    end
    d0 = an_idx(bus.o_an);
    if (d0 < 0) chk("scan_start_an", {28'd0, bus.o_an}, 32'hE);
    else for (int j = 0; j < 5 * DIV; j++) begin
      chk($sformatf("scan_an_%0d", j), {28'd0, bus.o_an}, {28'd0, ~(4'b0001 << ((d0 + j / DIV) % 4))});
      chk($sformatf("scan_seg_%0d", j), {25'd0, bus.o_seg},
          ((d0 + j / DIV) % 4 == 0) ? 32'b1111000 : 32'b1111111);
      @(negedge clk);
    end
    foreach (vecs[i]) begin
      send(vecs[i].data, vecs[i].sign, vecs[i].bcd, vecs[i].neg);
      drain();
      check_display(vecs[i].bcd, vecs[i].neg);
    end
    @(negedge clk);
    bus.i_valid = 1'b1;
    bus.i_data  = 8'h10;
    bus.i_sign  = 1'b0;
    @(posedge clk);
    #1;
    sb.push_back('{12'h016, 1'b0, cyc});
    bus.i_data = 8'h21;
    n = 0;
    @(negedge clk);
    while (!bus.o_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_done_at_ready", {31'd0, bus.o_done}, 32'd1);
    chk("b2b_wait", n, NB_DATA + 1);
    @(posedge clk);
    #1;
    sb.push_back('{12'h033, 1'b0, cyc});
    bus.i_valid = 1'b0;
    for (int j = 0; j < NB_DATA; j++) begin
      @(negedge clk);
      chk("b2b_hold_bcd", {20'd0, bus.o_bcd}, 32'h016);
    end
    drain();
    send(8'd55, 1'b0, 12'h055, 1'b0);
    drain();
    @(negedge clk);
    bus.i_valid = 1'b1;
    bus.i_data  = 8'd200;
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_reset_state("abort");
    repeat (3 * NB_DATA) @(negedge clk);
    chk("abort_bcd_stays", {20'd0, bus.o_bcd}, 32'd0);
    send(8'hD6, 1'b1, 12'h042, 1'b1);
    drain();
    check_display(12'h042, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
